// File: rtl/sync_event_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_event_counter_if
// Description : Bundles the control, event and status signals of
//               sync_event_counter into one interface. The clock (clkAB)
//               and reset (rst) are not part of it; they stay plain ports.
//   master : drives en/di/dir/load/load_val/clr_flags/thresh and
//            observes count/tc/thr_hit/ovf/sticky
//   slave  : the counter side (the reverse directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_event_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             di;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_flags;
  logic [WIDTH-1:0] thresh;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             thr_hit;
  logic             ovf;
  logic             sticky;

  modport master (
    output en, di, dir, load, load_val, clr_flags, thresh,
    input  count, tc, thr_hit, ovf, sticky
  );

  modport slave (
    input  en, di, dir, load, load_val, clr_flags, thresh,
    output count, tc, thr_hit, ovf, sticky
  );
endinterface
`default_nettype wire

// File: rtl/sync_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : sync_event_counter
// Description : Up/down event counter on the muxed clock clkAB. Counts
//               qualified pulses on di, with synchronous load, wrap or
//               saturate at the range bounds, threshold compare, a one-cycle
//               terminal-count pulse and sticky ovf/sticky status flags.
// Ports       : clkAB - counter clock, all flops on posedge
//               rst   - synchronous active-high reset
//               bus   - sync_event_counter_if.slave (controls in, status out)
// Parameters  : WIDTH (>=2), MAXVAL (<= 2**WIDTH-1), MODE (0 wrap,
//               1 saturate), RST_VAL (<= MAXVAL)
// Config      : SYNC_EVENT_CNT_DI_SYNC_EN - when defined, di passes through
//               a 2-flop synchroniser before the step/sticky logic
//               (two extra cycles of di-to-count latency).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_event_counter #(
  parameter int          WIDTH   = 8,
  parameter int unsigned MAXVAL  = (2 ** WIDTH) - 1,
  parameter int          MODE    = 0,
  parameter int unsigned RST_VAL = 0
) (
  input  wire logic          clkAB,
  input  wire logic          rst,
  sync_event_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] c_MAXVAL  = WIDTH'(MAXVAL);
  localparam logic [WIDTH-1:0] c_RST_VAL = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] c_ZERO    = '0;
  localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
  localparam bit               c_SAT     = (MODE != 0);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_thr_hit;
  logic             r_ovf;
  logic             r_sticky;

  logic             w_di;
  logic             w_step;
  logic             w_bnd;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_nxt;

`ifdef SYNC_EVENT_CNT_DI_SYNC_EN
  logic r_di_meta;
  logic r_di_sync;

  always_ff @(posedge clkAB) begin
    if (rst) begin
      r_di_meta <= 1'b0;
      r_di_sync <= 1'b0;
    end else begin
      r_di_meta <= bus.di;
      r_di_sync <= r_di_meta;
    end
  end

  assign w_di = r_di_sync;
`else
  assign w_di = bus.di;
`endif

  // load takes precedence over a step on the same edge
  assign w_step         = bus.en & w_di & ~bus.load;
  assign w_load_clamped = (bus.load_val > c_MAXVAL) ? c_MAXVAL : bus.load_val;

  // Next count and boundary detection. Decrement/increment only happen away
  // from the bounds, so the WIDTH-bit arithmetic can never carry or borrow.
  always_comb begin
    w_count_nxt = r_count;
    w_bnd       = 1'b0;
    if (bus.load) begin
      w_count_nxt = w_load_clamped;
    end else if (w_step) begin
      if (bus.dir) begin
        if (r_count == c_ZERO) begin
          w_bnd       = 1'b1;
          w_count_nxt = c_SAT ? r_count : c_MAXVAL;
        end else begin
          w_count_nxt = r_count - c_ONE;
        end
      end else begin
        if (r_count >= c_MAXVAL) begin
          w_bnd       = 1'b1;
          w_count_nxt = c_SAT ? r_count : c_ZERO;
        end else begin
          w_count_nxt = r_count + c_ONE;
        end
      end
    end
  end

  // thr_hit compares the next count so it lines up with the registered
  // count; since count never exceeds MAXVAL a larger thresh cannot match.
  always_ff @(posedge clkAB) begin
    if (rst) begin
      r_count   <= c_RST_VAL;
      r_tc      <= 1'b0;
      r_ovf     <= 1'b0;
      r_sticky  <= 1'b0;
      r_thr_hit <= (c_RST_VAL == bus.thresh);
    end else begin
      r_count   <= w_count_nxt;
      r_tc      <= w_bnd;
      // a set condition beats clr_flags on the same edge
      r_ovf     <= w_bnd | (r_ovf & ~bus.clr_flags);
      r_sticky  <= w_di  | (r_sticky & ~bus.clr_flags);
      r_thr_hit <= (w_count_nxt == bus.thresh);
    end
  end

  assign bus.count   = r_count;
  assign bus.tc      = r_tc;
  assign bus.thr_hit = r_thr_hit;
  assign bus.ovf     = r_ovf;
  assign bus.sticky  = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_sync_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_event_counter
// Description : Directed self-checking bench. Two counters (WIDTH=4,
//               MAXVAL=9, RST_VAL=3), one wrapping (MODE=0) and one
//               saturating (MODE=1), share the same stimulus. Each status
//               sample packs {count, tc, ovf, thr_hit, sticky}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_event_counter;

  logic clkAB = 1'b0;
  logic rst;

  always #5 clkAB = ~clkAB;

  sync_event_counter_if #(.WIDTH(4)) m0 ();
  sync_event_counter_if #(.WIDTH(4)) m1 ();

  assign m1.en        = m0.en;
  assign m1.di        = m0.di;
  assign m1.dir       = m0.dir;
  assign m1.load      = m0.load;
  assign m1.load_val  = m0.load_val;
  assign m1.clr_flags = m0.clr_flags;
  assign m1.thresh    = m0.thresh;

  sync_event_counter #(.WIDTH(4), .MAXVAL(9), .MODE(0), .RST_VAL(3)) u_wrap (
    .clkAB (clkAB),
    .rst   (rst),
    .bus   (m0)
  );

  sync_event_counter #(.WIDTH(4), .MAXVAL(9), .MODE(1), .RST_VAL(3)) u_sat (
    .clkAB (clkAB),
    .rst   (rst),
    .bus   (m1)
  );

  logic [7:0] s0, s1;
  assign s0 = {m0.count, m0.tc, m0.ovf, m0.thr_hit, m0.sticky};
  assign s1 = {m1.count, m1.tc, m1.ovf, m1.thr_hit, m1.sticky};

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [7:0] ex(input int c, input bit tc, input bit ovf,
                                    input bit thr, input bit st);
    ex = {4'(c), tc, ovf, thr, st};
  endfunction

  task automatic tick();
    @(posedge clkAB);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0.thresh = 4'd3;
    tick();
    tick();
    vectors++; if (s0 !== ex(3,0,0,1,0)) begin miscompares++; $display("FAIL reset_wrap got %h exp %h", s0, ex(3,0,0,1,0)); end
    vectors++; if (s1 !== ex(3,0,0,1,0)) begin miscompares++; $display("FAIL reset_sat got %h exp %h", s1, ex(3,0,0,1,0)); end
    rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    m0.thresh = 4'd1; m0.load = 1'b1; m0.load_val = 4'd8;
    tick();
    vectors++; if (s0 !== ex(8,0,0,0,0)) begin miscompares++; $display("FAIL wrap_load got %h exp %h", s0, ex(8,0,0,0,0)); end
    m0.load = 1'b0; m0.en = 1'b1; m0.di = 1'b1; m0.dir = 1'b0;
    tick();
    vectors++; if (s0 !== ex(9,0,0,0,1)) begin miscompares++; $display("FAIL wrap_to9 got %h exp %h", s0, ex(9,0,0,0,1)); end
    tick();
    vectors++; if (s0 !== ex(0,1,1,0,1)) begin miscompares++; $display("FAIL wrap_to0 got %h exp %h", s0, ex(0,1,1,0,1)); end
    vectors++; if (s1 !== ex(9,1,1,0,1)) begin miscompares++; $display("FAIL sat_top1 got %h exp %h", s1, ex(9,1,1,0,1)); end
    tick();
    vectors++; if (s0 !== ex(1,0,1,1,1)) begin miscompares++; $display("FAIL wrap_to1 got %h exp %h", s0, ex(1,0,1,1,1)); end
    vectors++; if (s1 !== ex(9,1,1,0,1)) begin miscompares++; $display("FAIL sat_top2 got %h exp %h", s1, ex(9,1,1,0,1)); end
    m0.en = 1'b0; m0.di = 1'b0;
    tick();
    vectors++; if (s0 !== ex(1,0,1,1,1)) begin miscompares++; $display("FAIL wrap_ovf_hold got %h exp %h", s0, ex(1,0,1,1,1)); end
    m0.clr_flags = 1'b1;
    tick();
    vectors++; if (s0 !== ex(1,0,0,1,0)) begin miscompares++; $display("FAIL wrap_clr got %h exp %h", s0, ex(1,0,0,1,0)); end
    m0.clr_flags = 1'b0;
  endtask

  task automatic test_saturate_down();
    m0.load = 1'b1; m0.load_val = 4'd1; m0.dir = 1'b1;
    tick();
    vectors++; if (s1 !== ex(1,0,0,1,0)) begin miscompares++; $display("FAIL satd_load got %h exp %h", s1, ex(1,0,0,1,0)); end
    m0.load = 1'b0; m0.en = 1'b1; m0.di = 1'b1;
    tick();
    vectors++; if (s1 !== ex(0,0,0,0,1)) begin miscompares++; $display("FAIL satd_to0 got %h exp %h", s1, ex(0,0,0,0,1)); end
    tick();
    vectors++; if (s1 !== ex(0,1,1,0,1)) begin miscompares++; $display("FAIL satd_hold1 got %h exp %h", s1, ex(0,1,1,0,1)); end
    vectors++; if (s0 !== ex(9,1,1,0,1)) begin miscompares++; $display("FAIL wrapd_to9 got %h exp %h", s0, ex(9,1,1,0,1)); end
    tick();
    vectors++; if (s1 !== ex(0,1,1,0,1)) begin miscompares++; $display("FAIL satd_hold2 got %h exp %h", s1, ex(0,1,1,0,1)); end
    vectors++; if (s0 !== ex(8,0,1,0,1)) begin miscompares++; $display("FAIL wrapd_to8 got %h exp %h", s0, ex(8,0,1,0,1)); end
    m0.en = 1'b0; m0.di = 1'b0; m0.clr_flags = 1'b1;
    tick();
    vectors++; if (s1 !== ex(0,0,0,0,0)) begin miscompares++; $display("FAIL satd_clr got %h exp %h", s1, ex(0,0,0,0,0)); end
    m0.clr_flags = 1'b0;
  endtask

  task automatic test_load_clamp();
    m0.thresh = 4'd15; m0.load = 1'b1; m0.load_val = 4'd15;
    m0.en = 1'b1; m0.di = 1'b1; m0.dir = 1'b0;
    tick();
    vectors++; if (s0 !== ex(9,0,0,0,1)) begin miscompares++; $display("FAIL clamp_wrap got %h exp %h", s0, ex(9,0,0,0,1)); end
    vectors++; if (s1 !== ex(9,0,0,0,1)) begin miscompares++; $display("FAIL clamp_sat got %h exp %h", s1, ex(9,0,0,0,1)); end
    // at MAXVAL with a pending up-step: load must win, no boundary event
    m0.load_val = 4'd5;
    tick();
    vectors++; if (s0 !== ex(5,0,0,0,1)) begin miscompares++; $display("FAIL load_over_step got %h exp %h", s0, ex(5,0,0,0,1)); end
    m0.load = 1'b0; m0.en = 1'b0; m0.di = 1'b0; m0.clr_flags = 1'b1;
    tick();
    m0.clr_flags = 1'b0;
  endtask

  task automatic test_sticky();
    m0.thresh = 4'd5; m0.en = 1'b0; m0.di = 1'b1;
    tick();
    vectors++; if (s0 !== ex(5,0,0,1,1)) begin miscompares++; $display("FAIL sticky_set got %h exp %h", s0, ex(5,0,0,1,1)); end
    m0.di = 1'b0;
    tick();
    vectors++; if (s0 !== ex(5,0,0,1,1)) begin miscompares++; $display("FAIL sticky_hold got %h exp %h", s0, ex(5,0,0,1,1)); end
    m0.clr_flags = 1'b1; m0.di = 1'b1;
    tick();
    vectors++; if (s0 !== ex(5,0,0,1,1)) begin miscompares++; $display("FAIL sticky_clr_vs_set got %h exp %h", s0, ex(5,0,0,1,1)); end
    m0.di = 1'b0;
    tick();
    vectors++; if (s0 !== ex(5,0,0,1,0)) begin miscompares++; $display("FAIL sticky_clr got %h exp %h", s0, ex(5,0,0,1,0)); end
    m0.clr_flags = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    m0.load = 1'b1; m0.load_val = 4'd9;
    tick();
    m0.load = 1'b0; m0.en = 1'b1; m0.di = 1'b1; m0.dir = 1'b0;
    m0.thresh = 4'd3; rst = 1'b1;
    tick();
    vectors++; if (s0 !== ex(3,0,0,1,0)) begin miscompares++; $display("FAIL rst_bnd_wrap got %h exp %h", s0, ex(3,0,0,1,0)); end
    vectors++; if (s1 !== ex(3,0,0,1,0)) begin miscompares++; $display("FAIL rst_bnd_sat got %h exp %h", s1, ex(3,0,0,1,0)); end
    rst = 1'b0; m0.en = 1'b0; m0.di = 1'b0;
  endtask

  task automatic test_back_to_back();
    m0.load = 1'b1; m0.load_val = 4'd4;
    tick();
    m0.load = 1'b0; m0.en = 1'b1; m0.di = 1'b1; m0.dir = 1'b0;
    tick();
    vectors++; if (s0 !== ex(5,0,0,0,1)) begin miscompares++; $display("FAIL b2b_up got %h exp %h", s0, ex(5,0,0,0,1)); end
    m0.dir = 1'b1;
    tick();
    vectors++; if (s0 !== ex(4,0,0,0,1)) begin miscompares++; $display("FAIL b2b_down1 got %h exp %h", s0, ex(4,0,0,0,1)); end
    tick();
    vectors++; if (s1 !== ex(3,0,0,1,1)) begin miscompares++; $display("FAIL b2b_down2 got %h exp %h", s1, ex(3,0,0,1,1)); end
    m0.en = 1'b0; m0.di = 1'b0;
  endtask

  task automatic test_di_sync();
    m0.en = 1'b1; m0.dir = 1'b0; m0.di = 1'b1;
    tick();
    vectors++; if (s0 !== ex(3,0,0,1,0)) begin miscompares++; $display("FAIL sync_lat1 got %h exp %h", s0, ex(3,0,0,1,0)); end
    m0.di = 1'b0;
    tick();
    vectors++; if (s0 !== ex(3,0,0,1,0)) begin miscompares++; $display("FAIL sync_lat2 got %h exp %h", s0, ex(3,0,0,1,0)); end
    tick();
    vectors++; if (s0 !== ex(4,0,0,0,1)) begin miscompares++; $display("FAIL sync_step got %h exp %h", s0, ex(4,0,0,0,1)); end
    m0.en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0.en = 1'b0; m0.di = 1'b0; m0.dir = 1'b0; m0.load = 1'b0;
    m0.load_val = '0; m0.clr_flags = 1'b0; m0.thresh = '0;
    test_reset();
`ifdef SYNC_EVENT_CNT_DI_SYNC_EN
    test_di_sync();
`else
    test_wrap_up();
    test_saturate_down();
    test_load_clamp();
    test_sticky();
    test_reset_mid_count();
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
